// File: rtl/btm_pkg.sv
// Shared types and default constants for the barrier timeout monitor.
// Latency: none (declarations only).
// Backpressure: none.
package btm_pkg;

  // Per-channel FSM states. TRIPPED and RELEASING share bit 1 so "tripped" is a single-bit decode.
  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_ARMING    = 2'd1,
    ST_TRIPPED   = 2'd2,
    ST_RELEASING = 2'd3
  } btm_state_t;

  localparam int DEF_TRIP_CYCLES    = 50;
  localparam int DEF_RELEASE_CYCLES = 4;
  localparam int DEF_CNT_W          = 8;

  // Width and ceiling of the optional per-channel trip event counters.
  localparam int         TRIP_CNT_W   = 8;
  localparam logic [7:0] TRIP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/btm_channel.sv
// One sensor channel: trips after TRIP_CYCLES consecutive low samples, releases after RELEASE_CYCLES highs.
// Latency: tripped_o rises on the edge that takes in the TRIP_CYCLES-th low sample.
// Backpressure: none; one sample is taken every cycle.
module btm_channel
  import btm_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIP_CYCLES    = DEF_TRIP_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic mask_i,
  input  logic clear_i,
  input  logic sense_i,
  output logic tripped_o,
  output logic tripped_d_o
);

  localparam logic [CNT_W-1:0] TRIP_C = CNT_W'(TRIP_CYCLES);
  localparam logic [CNT_W-1:0] REL_C  = CNT_W'(RELEASE_CYCLES);

  btm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tripped_q;

  // Next state: forced clears take priority over the normal run-length step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (!enable_i || !mask_i || clear_i) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (!sense_i) begin
            if (TRIP_CYCLES == 1) begin
              state_d = ST_TRIPPED;
              cnt_d   = '0;
            end else begin
              state_d = ST_ARMING;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_ARMING: begin
          if (!sense_i) begin
            if (cnt_inc == TRIP_C) begin
              state_d = ST_TRIPPED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
        ST_TRIPPED: begin
          if (sense_i) begin
            if (RELEASE_CYCLES == 1) begin
              state_d = ST_CLEAR;
              cnt_d   = '0;
            end else begin
              state_d = ST_RELEASING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_RELEASING: begin
          if (sense_i) begin
            if (cnt_inc == REL_C) begin
              state_d = ST_CLEAR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_TRIPPED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign tripped_d_o = state_d[1];

  // State, run counter and the registered trip flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      tripped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tripped_q <= state_d[1];
    end
  end

  assign tripped_o = tripped_q;

endmodule

// File: rtl/barrier_timeout_monitor.sv
// Multi-channel no-barrier monitor: per-channel trip flags, aggregate flags, first-tripped index.
// Latency: all outputs registered, updated on the same edge as the channel trip flags.
// Backpressure: none. Optional macro BTM_TRIP_COUNT_EN adds saturating per-channel trip counters.
module barrier_timeout_monitor
  import btm_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIP_CYCLES    = DEF_TRIP_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int CH_IDX_W       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [NUM_CH-1:0]   sense_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
  input  logic                clear_i,
  output logic [NUM_CH-1:0]   tripped_o,
  output logic                any_tripped_o,
  output logic                all_tripped_o,
  output logic [CH_IDX_W-1:0] first_ch_o,
  output logic                first_valid_o
`ifdef BTM_TRIP_COUNT_EN
  ,
  output logic [NUM_CH*TRIP_CNT_W-1:0] trip_count_o
`endif
);

  logic [NUM_CH-1:0]   tripped_d;
  logic                any_d, all_d;
  logic                any_q, all_q;
  logic [CH_IDX_W-1:0] first_idx;
  logic [CH_IDX_W-1:0] first_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btm_channel #(
      .CNT_W          (CNT_W),
      .TRIP_CYCLES    (TRIP_CYCLES),
      .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (enable_i),
      .mask_i      (ch_mask_i[g]),
      .clear_i     (clear_i),
      .sense_i     (sense_i[g]),
      .tripped_o   (tripped_o[g]),
      .tripped_d_o (tripped_d[g])
    );
  end

  // Aggregates are formed from next-state flags so they register alongside the channel flags.
  always_comb begin
    any_d     = |tripped_d;
    all_d     = (|ch_mask_i) && (&(tripped_d | ~ch_mask_i));
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (tripped_d[i]) first_idx = CH_IDX_W'(i);
    end
  end

  // first_ch latches on the rising edge of any_tripped and holds until everything has released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q   <= 1'b0;
      all_q   <= 1'b0;
      first_q <= '0;
    end else begin
      any_q <= any_d;
      all_q <= all_d;
      if (!any_d) begin
        first_q <= '0;
      end else if (!any_q) begin
        first_q <= first_idx;
      end
    end
  end

  assign any_tripped_o = any_q;
  assign all_tripped_o = all_q;
  assign first_ch_o    = first_q;
  assign first_valid_o = any_q;

`ifdef BTM_TRIP_COUNT_EN
  // A fresh trip is a 0->1 of the flag; RELEASING->TRIPPED keeps the flag high and is not counted.
  logic [NUM_CH-1:0] trip_evt;
  assign trip_evt = tripped_d & ~tripped_o;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tcnt
    logic [TRIP_CNT_W-1:0] tcnt_q;

    // Saturating trip counter; a masked channel keeps its count even through clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tcnt_q <= '0;
      end else if (!enable_i) begin
        tcnt_q <= '0;
      end else if (!ch_mask_i[g]) begin
        tcnt_q <= tcnt_q;
      end else if (clear_i) begin
        tcnt_q <= '0;
      end else if (trip_evt[g] && (tcnt_q != TRIP_CNT_MAX)) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end

    assign trip_count_o[g*TRIP_CNT_W +: TRIP_CNT_W] = tcnt_q;
  end
`endif

endmodule

// File: tb/tb_barrier_timeout_monitor.sv
// Self-checking bench for barrier_timeout_monitor (default parameters).
// Expected outputs come from a run-length reference model and flow through a scoreboard queue.
// Directed scenarios plus a randomised soak; optional trip counters checked when the macro is set.
module tb_barrier_timeout_monitor;

  localparam int NCH  = 4;
  localparam int TRIP = 50;
  localparam int REL  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [NCH-1:0]  sense = '1;
  logic [NCH-1:0]  ch_mask = '0;
  logic            clear = 1'b0;
  logic [NCH-1:0]  tripped;
  logic            any_tripped, all_tripped, first_valid;
  logic [1:0]      first_ch;
`ifdef BTM_TRIP_COUNT_EN
  logic [NCH*8-1:0] trip_count;
`endif

  always #5 clk = ~clk;

  barrier_timeout_monitor #(
    .NUM_CH(NCH), .CNT_W(8), .TRIP_CYCLES(TRIP), .RELEASE_CYCLES(REL), .CH_IDX_W(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .sense_i       (sense),
    .ch_mask_i     (ch_mask),
    .clear_i       (clear),
    .tripped_o     (tripped),
    .any_tripped_o (any_tripped),
    .all_tripped_o (all_tripped),
    .first_ch_o    (first_ch),
    .first_valid_o (first_valid)
`ifdef BTM_TRIP_COUNT_EN
    ,
    .trip_count_o  (trip_count)
`endif
  );

  typedef struct {
    logic [8:0]  v;
    logic [31:0] tc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state: trip flag plus length of the current run of "opposite" samples.
  bit   mt[NCH];
  int   mr[NCH];
  int   mtc[NCH];
  bit   many;
  int   mfirst;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mt[i] = 0; mr[i] = 0; mtc[i] = 0;
    end
    many = 0; mfirst = 0;
    sbq.delete();
  endtask

  task automatic model_step(input bit en, input logic [NCH-1:0] m, input bit clr,
                            input logic [NCH-1:0] s);
    bit   prev_any;
    bit   mall;
    exp_t e;
    prev_any = many;
    for (int i = 0; i < NCH; i++) begin
      if (!en) begin
        mt[i] = 0; mr[i] = 0; mtc[i] = 0;
      end else if (!m[i]) begin
        mt[i] = 0; mr[i] = 0;
      end else if (clr) begin
        mt[i] = 0; mr[i] = 0; mtc[i] = 0;
      end else if (!mt[i]) begin
        if (s[i]) mr[i] = 0;
        else begin
          mr[i]++;
          if (mr[i] == TRIP) begin
            mt[i] = 1; mr[i] = 0;
            if (mtc[i] < 255) mtc[i]++;
          end
        end
      end else begin
        if (!s[i]) mr[i] = 0;
        else begin
          mr[i]++;
          if (mr[i] == REL) begin
            mt[i] = 0; mr[i] = 0;
          end
        end
      end
    end
    many = 0;
    mall = (m != '0);
    for (int i = 0; i < NCH; i++) begin
      if (mt[i]) many = 1;
      if (m[i] && !mt[i]) mall = 0;
    end
    if (!many) mfirst = 0;
    else if (!prev_any) begin
      for (int i = NCH - 1; i >= 0; i--) if (mt[i]) mfirst = i;
    end
    e.v = {mt[3], mt[2], mt[1], mt[0], many, mall, 2'(mfirst), many};
    e.tc = {8'(mtc[3]), 8'(mtc[2]), 8'(mtc[1]), 8'(mtc[0])};
    sbq.push_back(e);
  endtask

  // Drive one cycle of stimulus, predict, then compare once the DUT has taken the edge.
  task automatic cyc(input bit en, input logic [NCH-1:0] m, input bit clr,
                     input logic [NCH-1:0] s);
    exp_t e;
    enable = en; ch_mask = m; clear = clr; sense = s;
    model_step(en, m, clr, s);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("outs", {tripped, any_tripped, all_tripped, first_ch, first_valid}, e.v);
`ifdef BTM_TRIP_COUNT_EN
      chk("tcnt", trip_count, e.tc);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 4'hF, 0, 4'hF);
  endtask

  initial begin
    int            hold[NCH];
    logic [NCH-1:0] rs, rm;
    model_reset();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tripped", tripped, 4'h0);
    chk("rst_any", any_tripped, 1'b0);
    chk("rst_all", all_tripped, 1'b0);
    chk("rst_first", first_ch, 2'd0);
    chk("rst_fvalid", first_valid, 1'b0);
`ifdef BTM_TRIP_COUNT_EN
    chk("rst_tcnt", trip_count, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Channel 0 trips on the 50th low sample, not the 49th.
    for (int k = 0; k < TRIP - 1; k++) cyc(1, 4'hF, 0, 4'b1110);
    chk("t1_49_tripped", tripped, 4'h0);
    cyc(1, 4'hF, 0, 4'b1110);
    chk("t1_50_tripped", tripped, 4'b0001);
    chk("t1_any", any_tripped, 1'b1);
    chk("t1_first", first_ch, 2'd0);
    chk("t1_all", all_tripped, 1'b0);
    idle(REL + 2);

    // A single high sample restarts channel 2's run.
    for (int k = 0; k < TRIP - 1; k++) cyc(1, 4'hF, 0, 4'b1011);
    cyc(1, 4'hF, 0, 4'hF);
    for (int k = 0; k < TRIP - 1; k++) cyc(1, 4'hF, 0, 4'b1011);
    chk("t2_99_tripped", tripped, 4'h0);
    cyc(1, 4'hF, 0, 4'b1011);
    chk("t2_100_tripped", tripped, 4'b0100);
    idle(REL + 2);

    // Release hysteresis on channel 1.
    for (int k = 0; k < TRIP; k++) cyc(1, 4'hF, 0, 4'b1101);
    for (int k = 0; k < 3; k++) cyc(1, 4'hF, 0, 4'hF);
    cyc(1, 4'hF, 0, 4'b1101);
    for (int k = 0; k < 3; k++) cyc(1, 4'hF, 0, 4'hF);
    chk("t3_hold_tripped", tripped, 4'b0010);
    cyc(1, 4'hF, 0, 4'hF);
    chk("t3_rel_tripped", tripped, 4'h0);
    chk("t3_rel_fvalid", first_valid, 1'b0);
    chk("t3_rel_first", first_ch, 2'd0);

    // Simultaneous trip of channels 1 and 3; first_ch holds through channel 1's release.
    for (int k = 0; k < TRIP; k++) cyc(1, 4'hF, 0, 4'b0101);
    chk("t4_tripped", tripped, 4'b1010);
    chk("t4_first", first_ch, 2'd1);
    for (int k = 0; k < REL; k++) cyc(1, 4'hF, 0, 4'b0111);
    chk("t4_rel1_tripped", tripped, 4'b1000);
    chk("t4_hold_first", first_ch, 2'd1);

    // Asynchronous reset mid-run clears everything immediately.
    rst_n = 1'b0;
    #1;
    chk("arst_tripped", tripped, 4'h0);
    chk("arst_fvalid", first_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Masked channels, all_tripped, enable drop and clear-restarted arming.
    for (int k = 0; k < TRIP; k++) cyc(1, 4'b0101, 0, 4'h0);
    chk("t5_tripped", tripped, 4'b0101);
    chk("t5_all", all_tripped, 1'b1);
    cyc(0, 4'b0101, 0, 4'h0);
    chk("t5_en_off", {tripped, any_tripped, all_tripped, first_ch, first_valid}, 9'h0);
    for (int k = 0; k < 29; k++) cyc(1, 4'b0101, 0, 4'h0);
    cyc(1, 4'b0101, 1, 4'h0);
    for (int k = 0; k < TRIP - 1; k++) cyc(1, 4'b0101, 0, 4'h0);
    chk("t5_clr_49", tripped, 4'h0);
    cyc(1, 4'b0101, 0, 4'h0);
    chk("t5_clr_50", tripped, 4'b0101);
    cyc(1, 4'h0, 0, 4'h0);
    chk("t5_nomask_all", all_tripped, 1'b0);
    idle(REL + 2);

    // Randomised soak: long held sensor runs, occasional mask/clear/enable events.
    for (int i = 0; i < NCH; i++) hold[i] = 0;
    rs = '1;
    rm = 4'hF;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (hold[i] == 0) begin
          rs[i] = 1'($urandom_range(0, 1));
          hold[i] = rs[i] ? $urandom_range(1, 8) : $urandom_range(30, 80);
        end else hold[i]--;
      end
      if ($urandom_range(0, 199) == 0) rm = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 299) != 0, rm, $urandom_range(0, 149) == 0, rs);
    end
    idle(REL + 2);

`ifdef BTM_TRIP_COUNT_EN
    // Trip counter saturation and clear.
    for (int r = 0; r < 300; r++) begin
      for (int k = 0; k < TRIP; k++) cyc(1, 4'hF, 0, 4'b1110);
      for (int k = 0; k < REL; k++) cyc(1, 4'hF, 0, 4'hF);
    end
    chk("tc_sat", trip_count[7:0], 8'd255);
    cyc(1, 4'hF, 1, 4'hF);
    chk("tc_clear", trip_count[7:0], 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/barrier_timeout_monitor.md
Name: barrier_timeout_monitor

Overview:
Multi-channel, parametrised successor to the single-channel no-barrier power-off detector. Each channel watches one obstacle-sensor line. A channel trips after a programmable run of consecutive "no barrier" samples, and releases only after a programmable run of consecutive "barrier" samples (hysteresis). Aggregated flags and a first-tripped channel index feed the car's power/motion control FSM.

Parameters:
NUM_CH, 4, number of sensor channels (legal 1..16)
CNT_W, 8, per-channel run counter width
TRIP_CYCLES, 50, consecutive low samples needed to trip (legal 1..2^CNT_W-1)
RELEASE_CYCLES, 4, consecutive high samples needed to release (legal 1..2^CNT_W-1)
CH_IDX_W, 2, index width; must be ≥ clog2(NUM_CH), minimum 1

Ports:
clk  in  1  system clock
rst_n  in  1  reset
enable  in  1  monitor enable; low = synchronous clear of all state
sense  in  NUM_CH  per-channel sensor; 1 = barrier present, 0 = no barrier
ch_mask  in  NUM_CH  1 = channel monitored; 0 = channel held cleared
clear  in  1  single-cycle pulse; clears tripped state and counters
tripped  out  NUM_CH  per-channel trip flag (registered)
any_tripped  out  1  OR of tripped (registered, same cycle as tripped)
all_tripped  out  1  1 when every unmasked channel is tripped and ≥1 channel is unmasked
first_ch  out  CH_IDX_W  index of the first channel to trip since the last all-clear
first_valid  out  1  first_ch is meaningful (equals any_tripped)

Behaviour:
- Reset (rst_n): asynchronous, active-low; clock clk. All outputs 0, all counters 0, all channel FSMs in CLEAR.
- Per-channel FSM, 2-bit encoding: CLEAR=0, ARMING=1, TRIPPED=2, RELEASING=3.
  - CLEAR: sense=0 → ARMING, cnt=1. If TRIP_CYCLES=1, go directly to TRIPPED instead. sense=1 → stay, cnt=0.
  - ARMING: sense=0 → cnt+1; on the edge where cnt+1 == TRIP_CYCLES → TRIPPED, cnt=0. sense=1 → CLEAR, cnt=0.
  - TRIPPED: sense=1 → RELEASING, cnt=1. If RELEASE_CYCLES=1, go directly to CLEAR instead. sense=0 → stay.
  - RELEASING: sense=1 → cnt+1; on the edge where cnt+1 == RELEASE_CYCLES → CLEAR, cnt=0. sense=0 → TRIPPED, cnt=0.
- tripped[i] = 1 while state is TRIPPED or RELEASING.
- Trip latency: with low samples at edges 1..N (N=TRIP_CYCLES), tripped rises immediately after edge N. Release is symmetric with RELEASE_CYCLES.
- Counters never exceed their threshold and never wrap.
- Priority per edge, highest first: enable=0 > ch_mask[i]=0 > clear=1 > FSM step.
  - Each of the first three forces the affected channel(s) to CLEAR with cnt=0.
  - A clear pulse asserted while sense=0 restarts arming; the next trip then needs a full TRIP_CYCLES run.
- first_ch:
  - Loads on the edge where any_tripped goes 0→1. If several channels trip on the same edge, the lowest index wins.
  - Holds while any_tripped=1, even if that channel releases.
  - Returns to 0 when any_tripped returns to 0.
- all_tripped = 0 when ch_mask is all zeros.
- Asserting rst_n mid-run aborts everything immediately. No partial counts survive.

Optional Feature:
BTM_TRIP_COUNT_EN.
- Defined: adds output trip_count [NUM_CH*8-1:0], one 8-bit saturating counter per channel. Each counter increments on every entry to TRIPPED from CLEAR or ARMING (not RELEASING→TRIPPED) and saturates at 255. Counters clear on reset, on enable=0 and on clear; a masked channel's counter holds.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package btm_pkg: state typedef btm_state_t (the 2-bit enum above) and default constants (DEF_TRIP_CYCLES=50, DEF_RELEASE_CYCLES=4, DEF_CNT_W=8).
- Sub-module btm_channel: one FSM plus counter, instantiated NUM_CH times in a generate loop.
- The top level holds aggregation, first_ch capture and the optional trip counters.

Test Plan:
- Defaults. ch_mask=4'hF, sense[0]=0 for 50 cycles, others 1 → tripped=4'b0001 after edge 50 (not 49); any_tripped=1, first_ch=0, all_tripped=0.
- sense[2]=0 for 49 cycles, 1 for one cycle, then 0 for 50 cycles → no trip during the first run; trip after edge 100 of the sequence.
- Ch1 tripped; sense[1]=1 for 3 cycles, 0 for 1, then 1 for 4 → stays tripped until the 4th consecutive high sample, then tripped[1]=0, first_valid=0, first_ch=0.
- Ch3 and ch1 trip on the same edge → first_ch=1. Ch1 then releases while ch3 stays tripped → first_ch stays 1.
- ch_mask=4'b0101, sense=0 on all channels for 50 cycles → tripped=4'b0101, all_tripped=1. Drop enable for one cycle → all outputs 0 on the next edge. clear pulse at cycle 30 of a run → trip delayed to 50 cycles after the pulse.
- With BTM_TRIP_COUNT_EN: 300 trip/release cycles on ch0 → trip_count[7:0]=255. One clear pulse → 0.
